fir_sample_feeder: RTL and testbench

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

---
 rtl/fir_params.sv | 21 ++
 rtl/fir_sample_feeder_if.sv | 31 +++
 rtl/fir_sample_fifo.sv | 51 +++++
 rtl/fir_sample_feeder.sv | 170 +++++++++++++++++
 tb/tb_fir_sample_feeder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_params.sv
// fir_params: constants shared by the FIR datapath and its sample feeder.
// FLUSH state only exists when FIR_FEEDER_FLUSH_EN is defined.
package fir_params;

  localparam int IN_WIDTH = 16;
  localparam int N_TAPS   = 16;

`ifdef FIR_FEEDER_FLUSH_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } feeder_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RUN
  } feeder_state_t;
`endif

endpackage

// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: host write channel and FIR sample channel of the feeder.
// The slave modport is the feeder itself, the master modport its environment.
interface fir_sample_feeder_if;
  import fir_params::*;

  logic                       wr_valid;
  logic                       wr_ready;
  logic signed [IN_WIDTH-1:0] wr_data;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] sample_in;

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  in_ready,
    output wr_ready,
    output in_valid,
    output sample_in
  );

  modport master (
    output wr_valid,
    output wr_data,
    output in_ready,
    input  wr_ready,
    input  in_valid,
    input  sample_in
  );

endinterface

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: power-of-two sample FIFO whose popped word lands in a head
// register, so the consumer always sees a registered sample.
module fir_sample_fifo #(
  parameter int DEPTH    = 8,
  parameter int IN_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic signed [IN_WIDTH-1:0] wr_data,
  input  logic                       rd_en,
  output logic signed [IN_WIDTH-1:0] head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic signed [IN_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;

  // Storage array; a write into the slot being read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count spans 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
        head   <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers host samples and streams blocks of block_len
// samples to the FIR input; FIR_FEEDER_FLUSH_EN appends N_TAPS-1 zeros.
module fir_sample_feeder
  import fir_params::*;
#(
  parameter int DEPTH     = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fir_sample_feeder_if.slave   bus,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] block_len,
  output logic                 busy,
  output logic                 done
);
  localparam int                   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  feeder_state_t              state_q;
  feeder_state_t              state_d;
  logic [CW-1:0]              fifo_count;
  logic signed [IN_WIDTH-1:0] fifo_head;
  logic [LEN_WIDTH-1:0]       load_left_q;
  logic [LEN_WIDTH-1:0]       xfer_left_q;
  logic                       in_valid_q;
  logic                       done_q;
  logic                       pop;
  logic                       xfer;
  logic                       last_xfer;
  logic                       wr_en;
  logic                       wr_ready_w;

`ifdef FIR_FEEDER_FLUSH_EN
  localparam int            FW          = $clog2(N_TAPS) + 1;
  localparam logic [FW-1:0] FLUSH_ZEROS = FW'(N_TAPS - 1);
  logic [FW-1:0]            flush_left_q;
`endif

  assign xfer       = in_valid_q && bus.in_ready;
  assign last_xfer  = xfer && (xfer_left_q == LEN_ONE);
  assign wr_ready_w = (fifo_count != FULL_COUNT) || pop;
  assign wr_en      = bus.wr_valid && wr_ready_w;

  fir_sample_fifo #(
    .DEPTH    (DEPTH),
    .IN_WIDTH (IN_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .head    (fifo_head),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, plus the pop that refills the output register when it is free.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (block_len != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pop = (fifo_count != '0) && (load_left_q != '0) &&
              (!in_valid_q || bus.in_ready);
        if (last_xfer) begin
`ifdef FIR_FEEDER_FLUSH_EN
          state_d = FLUSH;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef FIR_FEEDER_FLUSH_EN
      FLUSH: begin
        if (xfer && (flush_left_q == FW'(1))) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Block counters, registered in_valid and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_left_q  <= '0;
      xfer_left_q  <= '0;
      in_valid_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef FIR_FEEDER_FLUSH_EN
      flush_left_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            load_left_q <= block_len;
            xfer_left_q <= block_len;
            done_q      <= (block_len == '0);
          end
        end
        RUN: begin
          if (pop) begin
            load_left_q <= load_left_q - LEN_ONE;
          end
          if (xfer) begin
            xfer_left_q <= xfer_left_q - LEN_ONE;
          end
          if (last_xfer) begin
`ifdef FIR_FEEDER_FLUSH_EN
            in_valid_q   <= 1'b1;
            flush_left_q <= FLUSH_ZEROS;
`else
            in_valid_q   <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else if (pop) begin
            in_valid_q <= 1'b1;
          end else if (xfer) begin
            in_valid_q <= 1'b0;
          end
        end
`ifdef FIR_FEEDER_FLUSH_EN
        FLUSH: begin
          if (xfer) begin
            if (flush_left_q == FW'(1)) begin
              in_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              flush_left_q <= flush_left_q - FW'(1);
            end
          end
        end
`endif
        default: begin
          in_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign bus.wr_ready = wr_ready_w;
  assign bus.in_valid = in_valid_q;
`ifdef FIR_FEEDER_FLUSH_EN
  assign bus.sample_in = (state_q == FLUSH) ? '0 : fifo_head;
`else
  assign bus.sample_in = fifo_head;
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed bench for fir_sample_feeder.
// Expected streams include N_TAPS-1 trailing zeros when FIR_FEEDER_FLUSH_EN is set.
module tb_fir_sample_feeder;
  import fir_params::*;

  localparam int DEPTH     = 8;
  localparam int LEN_WIDTH = 16;
`ifdef FIR_FEEDER_FLUSH_EN
  localparam int ZEROS = N_TAPS - 1;
`else
  localparam int ZEROS = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [LEN_WIDTH-1:0] block_len;
  logic                 busy;
  logic                 done;

  fir_sample_feeder_if bus();

  fir_sample_feeder #(
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .start     (start),
    .block_len (block_len),
    .busy      (busy),
    .done      (done)
  );

  int check_count = 0;
  int error_count = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int got_q[$];
  int got_cyc[$];

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Edge counter used to time-stamp transfers and done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every transfer and done pulse mid-cycle, ahead of the edge that commits it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        got_q.push_back(int'(bus.sample_in));
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  // Global guard so the bench can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic wv, input int wd, input logic st, input int len);
    bus.wr_valid = wv;
    bus.wr_data  = IN_WIDTH'(wd);
    start        = st;
    block_len    = LEN_WIDTH'(len);
    step();
    start        = 1'b0;
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, first + i, 1'b0, 0);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d = done_cnt;
    int n = 0;
    while (done_cnt == d && n < budget) begin
      step();
      n++;
    end
    check_output({tag, " done seen"}, (done_cnt != d) ? 1 : 0, 1);
  endtask

  task automatic wait_xfers(input int base, input int target, input string tag);
    int n = 0;
    while ((got_q.size() - base) < target && n < 100) begin
      step();
      n++;
    end
    check_output({tag, " reached"}, ((got_q.size() - base) >= target) ? 1 : 0, 1);
  endtask

  task automatic check_stream(input string tag, input int base, input int first,
                              input int n, input bit consec);
    int total = n + ZEROS;
    check_output({tag, " count"}, got_q.size() - base, total);
    for (int i = 0; i < total && (base + i) < got_q.size(); i++) begin
      check_output($sformatf("%s sample %0d", tag, i), got_q[base + i], (i < n) ? first + i : 0);
      if (consec && i > 0)
        check_output($sformatf("%s gap %0d", tag, i), got_cyc[base + i] - got_cyc[base + i - 1], 1);
    end
    if (got_q.size() > base)
      check_output({tag, " done timing"}, done_cyc - got_cyc[got_q.size() - 1], 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " wr_ready"},  bus.wr_ready,  1);
    check_output({tag, " busy"},      busy,          0);
    check_output({tag, " done"},      done,          0);
    check_output({tag, " in_valid"},  bus.in_valid,  0);
    check_output({tag, " sample_in"}, bus.sample_in, 0);
  endtask

  initial begin
    int base;
    int d0;
    int c0;
    int target;

    rst_n        = 1'b0;
    start        = 1'b0;
    block_len    = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.in_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Preload 1..4, block of 4 with in_ready held high.
    bus.in_ready = 1'b1;
    preload(1, 4);
    base = got_q.size();
    d0   = done_cnt;
    apply_stimulus(1'b0, 0, 1'b1, 4);
    c0 = cyc;
    wait_done(100, "t1");
    repeat (3) step();
    check_stream("t1", base, 1, 4, 1'b1);
    check_output("t1 latency", got_cyc[base] - c0, 1);
    check_output("t1 done pulses", done_cnt - d0, 1);

    // Five-cycle stall after two transfers; head must hold 12.
    preload(10, 6);
    base = got_q.size();
    apply_stimulus(1'b0, 0, 1'b1, 6);
    wait_xfers(base, 2, "t2");
    bus.in_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("t2 stall valid %0d", k), bus.in_valid, 1);
      check_output($sformatf("t2 stall data %0d", k), bus.sample_in, 12);
    end
    @(posedge clk);
    #1;
    bus.in_ready = 1'b1;
    wait_done(100, "t2");
    repeat (2) step();
    check_stream("t2", base, 10, 6, 1'b0);

    // Fill to DEPTH, then run while writing into a full FIFO.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 20 + i, 1'b0, 0);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_output("t3 full wr_ready", bus.wr_ready, 0);
    check_output("t3 full busy", busy, 0);
    @(posedge clk);
    #1;
    base = got_q.size();
    apply_stimulus(1'b1, 28, 1'b1, 8);
    for (int k = 0; k < 4; k++) begin
      bus.wr_data = IN_WIDTH'(28 + k);
      @(negedge clk);
      check_output($sformatf("t3 write-through %0d", k), bus.wr_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    wait_done(100, "t3");
    repeat (2) step();
    check_stream("t3", base, 20, 8, 1'b1);

    // Zero-length block with 28..31 still buffered.
    apply_stimulus(1'b0, 0, 1'b1, 0);
    @(negedge clk);
    check_output("t4 done", done, 1);
    check_output("t4 busy", busy, 0);
    check_output("t4 in_valid", bus.in_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t4 done after", done, 0);
    check_output("t4 busy after", busy, 0);
    check_output("t4 in_valid after", bus.in_valid, 0);
    @(posedge clk);
    #1;

    // Leftover samples feed the next block.
    base = got_q.size();
    apply_stimulus(1'b0, 0, 1'b1, 4);
    wait_done(100, "t5");
    repeat (2) step();
    check_stream("t5", base, 28, 4, 1'b1);

    // Restart while busy with block_len=9 is ignored.
    bus.in_ready = 1'b0;
    preload(40, 3);
    base = got_q.size();
    d0   = done_cnt;
    apply_stimulus(1'b0, 0, 1'b1, 3);
    repeat (2) step();
    apply_stimulus(1'b0, 0, 1'b1, 9);
    bus.in_ready = 1'b1;
    wait_done(100, "t6");
    repeat (4) step();
    check_stream("t6", base, 40, 3, 1'b1);
    check_output("t6 done pulses", done_cnt - d0, 1);
    @(negedge clk);
    check_output("t6 busy after", busy, 0);
    check_output("t6 in_valid after", bus.in_valid, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-block (after 3 zeros when flushing), then a fresh block.
    preload(50, 4);
    base   = got_q.size();
    target = (ZEROS > 0) ? 7 : 2;
    apply_stimulus(1'b0, 0, 1'b1, 4);
    wait_xfers(base, target, "t7");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7 reset");
    step();
    rst_n = 1'b1;
    step();
    preload(60, 3);
    base = got_q.size();
    apply_stimulus(1'b0, 0, 1'b1, 3);
    wait_done(100, "t8");
    repeat (2) step();
    check_stream("t8", base, 60, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
